max7219_msg_sched: RTL and testbench

- Sequences character messages onto the MAX7219 character driver (max7219_basemod) through its iCall/oDone handshake.
- Holds each character for a programmable dwell time.
- Arbitrates between the message player and a priority alert requester.
- Sits between host/demo logic and max7219_basemod. Replaces free-running 1 Hz call loops with a proper done-gated sequence on the main 50 MHz clock.

---
 rtl/max7219_pkg.sv | 30 +++
 rtl/max7219_dwell_timer.sv | 27 ++
 rtl/max7219_msg_sched.sv | 179 +++++++++++++++++
 tb/tb_max7219_msg_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 message scheduler: character codes,
// FSM state encoding and datapath widths.
package max7219_pkg;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned TMR_W  = 26;

    // Character codes understood by max7219_basemod
    localparam logic [DATA_W-1:0] data_0 = 6'd0,  data_1 = 6'd1,  data_2 = 6'd2,  data_3 = 6'd3;
    localparam logic [DATA_W-1:0] data_4 = 6'd4,  data_5 = 6'd5,  data_6 = 6'd6,  data_7 = 6'd7;
    localparam logic [DATA_W-1:0] data_8 = 6'd8,  data_9 = 6'd9;
    localparam logic [DATA_W-1:0] data_A = 6'd10, data_B = 6'd11, data_C = 6'd12, data_D = 6'd13;
    localparam logic [DATA_W-1:0] data_E = 6'd14, data_F = 6'd15, data_G = 6'd16, data_H = 6'd17;
    localparam logic [DATA_W-1:0] data_I = 6'd18, data_J = 6'd19, data_K = 6'd20, data_L = 6'd21;
    localparam logic [DATA_W-1:0] data_M = 6'd22, data_N = 6'd23, data_O = 6'd24, data_P = 6'd25;
    localparam logic [DATA_W-1:0] data_Q = 6'd26, data_R = 6'd27, data_S = 6'd28, data_T = 6'd29;
    localparam logic [DATA_W-1:0] data_U = 6'd30, data_V = 6'd31, data_W = 6'd32, data_X = 6'd33;
    localparam logic [DATA_W-1:0] data_Y = 6'd34, data_Z = 6'd35;
    localparam logic [DATA_W-1:0] data_zhong = 6'd36, data_guo = 6'd37;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CALL    = 3'd2,
        ST_DWELL   = 3'd3,
        ST_A_CALL  = 3'd4,
        ST_A_DWELL = 3'd5
    } state_t;

endpackage

// File: rtl/max7219_dwell_timer.sv
// Down-counter shared by the dwell and iDone-timeout measurements.
// Loading N-1 makes o_expire_c rise in the N-th cycle after the load edge.
module max7219_dwell_timer
    import max7219_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_value,
    output logic             o_expire_c
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_expire_c = (r_count == '0);

endmodule

// File: rtl/max7219_msg_sched.sv
// Done-gated message player for max7219_basemod with dwell timing,
// iDone timeout and a priority single-character alert path.
module max7219_msg_sched
    import max7219_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned DONE_TIMEOUT = 1_000_000,
    localparam int unsigned IDX_W       = $clog2(MAX_LEN)
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              iWrEn,
    input  logic [IDX_W-1:0]  iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iStart,
    input  logic [IDX_W-1:0]  iLen,
    input  logic              iLoop,
    input  logic              iStop,
    input  logic              iAlertReq,
    input  logic [DATA_W-1:0] iAlertData,
    output logic              oAlertAck,
    output logic              oCall,
    output logic [DATA_W-1:0] oData,
    input  logic              iDone,
    output logic              oBusy,
    output logic [IDX_W-1:0]  oIndex,
    output logic              oMsgDone,
    output logic              oErr
);

    logic [DATA_W-1:0] r_buf [MAX_LEN];
    state_t            r_state;
    logic [IDX_W-1:0]  r_len;
    logic              r_loop;
    logic              r_stop;
    logic              r_playing;

    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_value;
    logic              w_tmr_expire;
    logic              w_in_call;
    logic              w_adv_end;
    logic [IDX_W-1:0]  w_adv_idx;

    // Message buffer is deliberately left out of reset
    always_ff @(posedge CLOCK) begin
        if (iWrEn) begin
            r_buf[iWrAddr] <= iWrData;
        end
    end

    // Timer reload: timeout on every way into a call, dwell when a call ends
    always_comb begin
        w_in_call   = (r_state == ST_CALL) || (r_state == ST_A_CALL);
        w_tmr_load  = 1'b0;
        w_tmr_value = TMR_W'(DONE_TIMEOUT - 1);
        if (w_in_call) begin
            w_tmr_load  = iDone || w_tmr_expire;
            w_tmr_value = TMR_W'(DWELL_CYCLES - 1);
        end else if ((r_state == ST_IDLE) || (r_state == ST_FETCH)) begin
            w_tmr_load  = 1'b1;
        end else begin
            w_tmr_load  = w_tmr_expire;
        end
    end

    // Character-boundary decision shared by the normal and post-alert exits
    always_comb begin
        w_adv_end = r_stop || iStop || ((oIndex == r_len) && !r_loop);
        w_adv_idx = (oIndex == r_len) ? '0 : IDX_W'(oIndex + 1'b1);
    end

    max7219_dwell_timer u_timer (
        .i_clk      (CLOCK),
        .i_rst      (RST),
        .i_load     (w_tmr_load),
        .i_value    (w_tmr_value),
        .o_expire_c (w_tmr_expire)
    );

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_loop    <= 1'b0;
            r_stop    <= 1'b0;
            r_playing <= 1'b0;
            oCall     <= 1'b0;
            oData     <= '0;
            oBusy     <= 1'b0;
            oIndex    <= '0;
            oMsgDone  <= 1'b0;
            oErr      <= 1'b0;
            oAlertAck <= 1'b0;
        end else begin
            oMsgDone  <= 1'b0;
            oErr      <= 1'b0;
            oAlertAck <= 1'b0;
            if (iStop && (r_state != ST_IDLE)) begin
                r_stop <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (iAlertReq) begin
                        r_playing <= 1'b0;
                        oData     <= iAlertData;
                        oCall     <= 1'b1;
                        oBusy     <= 1'b1;
                        r_state   <= ST_A_CALL;
                    end else if (iStart) begin
                        r_len   <= iLen;
                        r_loop  <= iLoop;
                        oIndex  <= '0;
                        oBusy   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    oData   <= r_buf[oIndex];
                    oCall   <= 1'b1;
                    r_state <= ST_CALL;
                end

                // A timed-out call still counts as shown and goes on to dwell
                ST_CALL, ST_A_CALL: begin
                    if (iDone || w_tmr_expire) begin
                        oCall   <= 1'b0;
                        oErr    <= !iDone;
                        r_state <= (r_state == ST_CALL) ? ST_DWELL : ST_A_DWELL;
                    end
                end

                ST_DWELL: begin
                    if (w_tmr_expire) begin
                        if (iAlertReq) begin
                            r_playing <= 1'b1;
                            oData     <= iAlertData;
                            oCall     <= 1'b1;
                            r_state   <= ST_A_CALL;
                        end else if (w_adv_end) begin
                            oMsgDone <= 1'b1;
                            oBusy    <= 1'b0;
                            r_stop   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            oIndex  <= w_adv_idx;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                ST_A_DWELL: begin
                    if (w_tmr_expire) begin
                        oAlertAck <= 1'b1;
                        if (!r_playing || w_adv_end) begin
                            oMsgDone <= r_playing;
                            oBusy    <= 1'b0;
                            r_stop   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            oIndex  <= w_adv_idx;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    oCall   <= 1'b0;
                    oBusy   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_msg_sched.sv
// Scoreboard bench for max7219_msg_sched with a simple basemod iDone model.
module tb_max7219_msg_sched;

    localparam int DW       = 6;
    localparam int DWELL    = 100;
    localparam int TMO      = 50;
    localparam int DONE_LAT = 5;
    localparam int CHAR_CYC = 1 + DONE_LAT + DWELL;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    idx;
        logic          chk_idx;
    } exp_t;

    logic          CLOCK = 1'b0;
    logic          RST   = 1'b0;
    logic          iWrEn = 1'b0;
    logic [3:0]    iWrAddr = '0;
    logic [DW-1:0] iWrData = '0;
    logic          iStart = 1'b0;
    logic [3:0]    iLen = '0;
    logic          iLoop = 1'b0;
    logic          iStop = 1'b0;
    logic          iAlertReq = 1'b0;
    logic [DW-1:0] iAlertData = '0;
    logic          iDone = 1'b0;
    logic          oAlertAck, oCall, oBusy, oMsgDone, oErr;
    logic [DW-1:0] oData;
    logic [3:0]    oIndex;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, call_cyc = 0, start_cyc = 0, age = 0;
    int   n_calls = 0, n_msg = 0, n_ack = 0, n_err = 0;
    int   b_calls, b_msg, b_ack, b_err;
    logic prev_call = 1'b0, sent = 1'b0, mute = 1'b0, ack_busy_exp = 1'b0;
    logic [DW-1:0] open_msg [4];

    max7219_msg_sched #(
        .MAX_LEN      (16),
        .DWELL_CYCLES (DWELL),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .CLOCK      (CLOCK),
        .RST        (RST),
        .iWrEn      (iWrEn),
        .iWrAddr    (iWrAddr),
        .iWrData    (iWrData),
        .iStart     (iStart),
        .iLen       (iLen),
        .iLoop      (iLoop),
        .iStop      (iStop),
        .iAlertReq  (iAlertReq),
        .iAlertData (iAlertData),
        .oAlertAck  (oAlertAck),
        .oCall      (oCall),
        .oData      (oData),
        .iDone      (iDone),
        .oBusy      (oBusy),
        .oIndex     (oIndex),
        .oMsgDone   (oMsgDone),
        .oErr       (oErr)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // One cycle: sample on the falling edge, score outputs, then advance the basemod model
    task automatic tick();
        exp_t e;
        @(negedge CLOCK);
        cyc++;
        if (oCall && !prev_call) begin
            n_calls++;
            call_cyc = cyc;
            check("call_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("call_data", oData, e.data);
                if (e.chk_idx) check("call_index", oIndex, e.idx);
            end
        end
        if (iDone) check("call_drop", oCall, 0);
        if (oMsgDone) n_msg++;
        if (oAlertAck) begin
            n_ack++;
            check("ack_busy", oBusy, ack_busy_exp);
        end
        if (oErr) begin
            n_err++;
            check("err_latency", 32'(cyc - call_cyc), TMO);
            check("err_call_low", oCall, 0);
        end
        if (!oCall) begin
            age = 0; sent = 1'b0; iDone = 1'b0;
        end else begin
            age++;
            if (!mute && !sent && age == DONE_LAT) begin
                iDone = 1'b1; sent = 1'b1;
            end else begin
                iDone = 1'b0;
            end
        end
        prev_call = oCall;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return n_calls;
            1:       return n_msg;
            default: return n_ack;
        endcase
    endfunction

    task automatic wait_count(input string tag, input int which, input int target, input int budget);
        int k = 0;
        while (cnt_of(which) < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(cnt_of(which) >= target), 1);
    endtask

    task automatic push(input logic [DW-1:0] d, input int idx, input logic chk);
        exp_t e;
        e.data = d; e.idx = 4'(idx); e.chk_idx = chk;
        exp_q.push_back(e);
    endtask

    task automatic push_open(input int first, input int last);
        for (int i = first; i <= last; i++) push(open_msg[i % 4], i % 4, 1'b1);
    endtask

    task automatic start_msg(input logic [3:0] len, input logic loop);
        iStart = 1'b1; iLen = len; iLoop = loop; start_cyc = cyc;
        tick();
        iStart = 1'b0;
    endtask

    task automatic snap();
        b_calls = n_calls; b_msg = n_msg; b_ack = n_ack; b_err = n_err;
    endtask

    task automatic end_checks(input string tag, input int calls, input int msgs, input int acks, input int errs);
        repeat (20) tick();
        check({tag, "_calls"}, 32'(n_calls - b_calls), calls);
        check({tag, "_msgdone"}, 32'(n_msg - b_msg), msgs);
        check({tag, "_acks"}, 32'(n_ack - b_ack), acks);
        check({tag, "_errs"}, 32'(n_err - b_err), errs);
        check({tag, "_queue"}, 32'(exp_q.size()), 0);
        check({tag, "_idle"}, oBusy, 0);
    endtask

    initial begin
        int k;
        open_msg[0] = 6'd24; open_msg[1] = 6'd25; open_msg[2] = 6'd14; open_msg[3] = 6'd23;

        RST = 1'b1;
        repeat (3) tick();
        check("rst_call", oCall, 0);
        check("rst_data", oData, 0);
        check("rst_busy", oBusy, 0);
        check("rst_index", oIndex, 0);
        check("rst_msgdone", oMsgDone, 0);
        check("rst_err", oErr, 0);
        check("rst_ack", oAlertAck, 0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            iWrEn = 1'b1; iWrAddr = 4'(i); iWrData = open_msg[i];
            tick();
        end
        iWrEn = 1'b0;

        // Asynchronous reset in the middle of a call
        push(open_msg[0], 0, 1'b1);
        start_msg(4'd3, 1'b0);
        wait_count("midrst_call_seen", 0, n_calls + 1, 10);
        #2 RST = 1'b1;
        #1;
        check("midrst_call", oCall, 0);
        check("midrst_busy", oBusy, 0);
        check("midrst_data", oData, 0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Plain message; a second iStart while busy must be ignored
        snap();
        ack_busy_exp = 1'b1;
        push_open(0, 3);
        start_msg(4'd3, 1'b0);
        wait_count("open_first_call", 0, b_calls + 1, 10);
        check("start_latency", 32'(cyc - start_cyc), 2);
        k = start_cyc;
        repeat (20) tick();
        iStart = 1'b1; iLen = 4'd0;
        tick();
        iStart = 1'b0;
        wait_count("open_msgdone_seen", 1, b_msg + 1, 6 * CHAR_CYC);
        check("open_msg_latency", 32'(cyc - k), 1 + 4 * CHAR_CYC);
        end_checks("open", 4, 1, 0, 0);

        // Looping message stopped during the second pass at index 1
        snap();
        push_open(0, 5);
        start_msg(4'd3, 1'b1);
        wait_count("loop_calls_seen", 0, b_calls + 6, 8 * CHAR_CYC);
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        wait_count("loop_msgdone_seen", 1, b_msg + 1, 2 * CHAR_CYC);
        end_checks("loop", 6, 1, 0, 0);

        // Stop pulse while idle must not be latched
        iStop = 1'b1;
        tick();
        iStop = 1'b0;

        // Alert inserted after the dwell of index 1
        snap();
        push(open_msg[0], 0, 1'b1);
        push(open_msg[1], 1, 1'b1);
        push(6'd36, 0, 1'b0);
        push(open_msg[2], 2, 1'b1);
        push(open_msg[3], 3, 1'b1);
        start_msg(4'd3, 1'b0);
        wait_count("alert_idx1_seen", 0, b_calls + 2, 3 * CHAR_CYC);
        k = 0;
        while (oCall && k < 50) begin tick(); k++; end
        check("alert_idx1_released", oCall, 0);
        repeat (10) tick();
        iAlertReq = 1'b1; iAlertData = 6'd36;
        wait_count("alert_call_seen", 0, b_calls + 3, 2 * CHAR_CYC);
        iAlertReq = 1'b0;
        wait_count("alert_msgdone_seen", 1, b_msg + 1, 4 * CHAR_CYC);
        end_checks("alert", 5, 1, 1, 0);

        // Basemod never answers: each call times out and playback continues
        snap();
        mute = 1'b1;
        push_open(0, 1);
        start_msg(4'd1, 1'b0);
        wait_count("tmo_msgdone_seen", 1, b_msg + 1, 4 * (1 + TMO + DWELL));
        mute = 1'b0;
        end_checks("tmo", 2, 1, 0, 2);

        // Start and alert in the same idle cycle: alert wins, start dropped
        snap();
        ack_busy_exp = 1'b0;
        push(6'd37, 0, 1'b0);
        iStart = 1'b1; iLen = 4'd3; iLoop = 1'b0;
        iAlertReq = 1'b1; iAlertData = 6'd37;
        tick();
        iStart = 1'b0; iAlertReq = 1'b0;
        wait_count("both_ack_seen", 2, b_ack + 1, 2 * CHAR_CYC);
        end_checks("both", 1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
